// File: rtl/j1_if.sv
// j1_if: RAM and I/O bus of the j1 core; j1 is the master, memory/IO fabric the slave.
interface j1_if;
  logic        io_read_enable;
  logic        io_write_enable;
  logic [0:15] io_addr;
  logic [0:15] io_write_data;
  logic [0:15] io_read_data;
  logic        mem_read_enable;
  logic [0:15] mem_read_address;
  logic [0:15] mem_read_data;
  logic        mem_write_enable;
  logic [0:15] mem_write_address;
  logic [0:15] mem_write_data;
  modport master (
    output io_read_enable, io_write_enable, io_addr, io_write_data,
    output mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_data,
    input  io_read_data, mem_read_data
  );
  modport slave (
    input  io_read_enable, io_write_enable, io_addr, io_write_data,
    input  mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_data,
    output io_read_data, mem_read_data
  );
endinterface

// File: rtl/j1.sv
// j1: 16-bit multi-cycle register/stack CPU core (FETCH/EXEC/WB/HALT).
// Define J1_STACK_GUARD_EN to halt on stack overflow/underflow instead of wrapping.
module j1 #(
  parameter int          STACK_DEPTH = 16,
  parameter logic [0:15] RESET_PC    = 16'h0000
) (
  input logic clk,
  input logic resetq,
  j1_if.master bus
);
  localparam int W = $clog2(STACK_DEPTH);
  typedef enum logic [0:2] {FETCH, EXEC, WB, HALT} state_t;
  state_t      current_state;
  logic [0:15] pc, st0, ir;
  logic [0:15] r  [0:3];
  logic [0:15] st [0:STACK_DEPTH-1];
  logic [0:W-1] sp;
  logic        register_write_enable;
  logic [0:15] ins, imm, sv, dv, pc1, alu, wd, nxt;
  logic [0:3]  op, aop;
  logic [0:1]  d, s;
  logic        fetch, exec, push, pop, stall, wr_ex, unused;
`ifdef J1_STACK_GUARD_EN
  logic [0:W] depth;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) depth <= '0;
    else if (!stall) depth <= depth + (W+1)'(push) - (W+1)'(pop);
`endif
  always_comb begin
    ins   = bus.mem_read_data;
    op    = ins[0:3];
    d     = ins[4:5];
    s     = ins[6:7];
    imm   = {8'h00, ins[8:15]};
    aop   = ins[8:11];
    sv    = r[s];
    dv    = r[d];
    pc1   = pc + 16'd1;
    fetch = resetq && current_state == FETCH;
    exec  = resetq && current_state == EXEC;
    push  = exec && (op == 4'd7 || op == 4'd10);
    pop   = exec && (op == 4'd9 || op == 4'd11);
`ifdef J1_STACK_GUARD_EN
    stall = (push && depth == (W+1)'(STACK_DEPTH)) || (pop && depth == '0);
`else
    stall = 1'b0;
`endif
    alu = aop == 4'd0 ? dv + sv : aop == 4'd1 ? dv - sv : aop == 4'd2 ? dv & sv :
          aop == 4'd3 ? dv | sv : aop == 4'd4 ? dv ^ sv : aop == 4'd5 ? ~sv :
          aop == 4'd6 ? dv << 1 : aop == 4'd7 ? dv >> 1 : dv;
    wd  = op == 4'd0 ? sv : op == 4'd1 ? imm : op == 4'd6 ? alu : op == 4'd11 ? st0 : bus.io_read_data;
    nxt = (op == 4'd7 || op == 4'd15) ? sv : op == 4'd9 ? st0 : op == 4'd14 ? imm :
          (op == 4'd8 && r[0] < sv) ? imm : op == 4'd13 ? pc : pc1;
    wr_ex = exec && !stall && (op == 4'd0 || op == 4'd1 || op == 4'd11 ||
            (op == 4'd6 && !ins[8]) || (op == 4'd12 && ins[8]));
    register_write_enable = wr_ex || (resetq && current_state == WB);
    // Requests are decoded straight from the instruction word so they land in EXEC itself.
    bus.mem_read_enable   = fetch || (exec && (op == 4'd2 || op == 4'd4));
    bus.mem_read_address  = fetch ? pc : (exec && op == 4'd2) ? imm : (exec && op == 4'd4) ? sv : '0;
    bus.mem_write_enable  = exec && (op == 4'd3 || op == 4'd5);
    bus.mem_write_address = !exec ? '0 : op == 4'd3 ? imm : op == 4'd5 ? dv : '0;
    bus.mem_write_data    = !exec ? '0 : op == 4'd3 ? dv : op == 4'd5 ? sv : '0;
    bus.io_write_enable   = exec && op == 4'd12 && !ins[8];
    bus.io_read_enable    = exec && op == 4'd12 && ins[8];
    bus.io_addr           = (bus.io_write_enable || bus.io_read_enable) ? imm : '0;
    bus.io_write_data     = bus.io_write_enable ? sv : '0;
    unused = ^{ir[0:3], ir[6:15]};
  end
  always_ff @(posedge clk)
    if (push && !stall) st[sp] <= st0;
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      current_state <= FETCH;
      pc  <= RESET_PC;
      st0 <= '0;
      sp  <= '0;
      ir  <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else if (current_state == FETCH) begin
      current_state <= EXEC;
    end else if (current_state == WB) begin
      r[ir[4:5]] <= bus.mem_read_data;
      current_state <= FETCH;
    end else if (current_state == EXEC) begin
      ir <= ins;
      if (stall) current_state <= HALT;
      else begin
        current_state <= op == 4'd13 ? HALT : (op == 4'd2 || op == 4'd4) ? WB : FETCH;
        pc <= nxt;
        if (wr_ex) r[d] <= wd;
        if (push) begin
          st0 <= op == 4'd7 ? pc1 : sv;
          sp  <= sp + 1'b1;
        end
        if (pop) begin
          st0 <= st[sp - 1'b1];
          sp  <= sp - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_j1.sv
// tb_j1: directed program checks plus random programs run against an instruction-level model.
module tb_j1;
  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;
  j1_if bus();
  j1 dut (.clk(clk), .resetq(resetq), .bus(bus));
  logic [15:0] ram [256];
  logic [15:0] iodat = 16'h0;
  int checks = 0, errors = 0;
  int rw_cnt = 0, mw_cnt = 0, io_cnt = 0, strobe_cnt = 0;
  logic [15:0] io_a = 16'h0, io_d = 16'h0;
  assign bus.io_read_data = iodat;
  always @(posedge clk) begin
    if (bus.mem_write_enable) ram[bus.mem_write_address[8:15]] <= bus.mem_write_data;
    if (bus.mem_read_enable) bus.mem_read_data <= ram[bus.mem_read_address[8:15]];
    if (dut.register_write_enable) rw_cnt <= rw_cnt + 1;
    if (bus.mem_write_enable) mw_cnt <= mw_cnt + 1;
    if (bus.io_write_enable) begin
      io_cnt <= io_cnt + 1;
      io_a <= bus.io_addr;
      io_d <= bus.io_write_data;
    end
    if (bus.mem_read_enable || bus.mem_write_enable || bus.io_read_enable || bus.io_write_enable)
      strobe_cnt <= strobe_cnt + 1;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic boot();
    resetq = 1'b1;
    #1 resetq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetq = 1'b1;
  endtask
  task automatic load(input logic [15:0] p[$]);
    for (int i = 0; i < 256; i++) ram[i] <= (i < p.size()) ? p[i] : 16'h0000;
  endtask
  // Instruction-level model state
  logic [15:0] mr [4];
  logic [15:0] mpc, mioa, miod;
  logic [15:0] mmem [256];
  logic [15:0] im [256];
  logic [15:0] mstk [$];
  int mrw, mmw, miow;
  bit mhalt;
  bit vis [128];
  task automatic iss(input logic [15:0] ins, output int cost);
    logic [3:0] op, aop;
    logic [1:0] d, s;
    logic [15:0] imm, sv, dv, nxt;
    op = ins[15:12]; d = ins[11:10]; s = ins[9:8]; imm = {8'h00, ins[7:0]}; aop = ins[7:4];
    sv = mr[s]; dv = mr[d]; nxt = mpc + 16'd1; cost = 2;
    case (op)
      4'd0: begin mr[d] = sv; mrw++; end
      4'd1: begin mr[d] = imm; mrw++; end
      4'd2: begin mr[d] = mmem[imm[7:0]]; mrw++; cost = 3; end
      4'd3: begin mmem[imm[7:0]] = dv; mmw++; end
      4'd4: begin mr[d] = mmem[sv[7:0]]; mrw++; cost = 3; end
      4'd5: begin mmem[dv[7:0]] = sv; mmw++; end
      4'd6: if (aop < 4'd8) begin
        case (aop)
          4'd0: mr[d] = dv + sv;
          4'd1: mr[d] = dv - sv;
          4'd2: mr[d] = dv & sv;
          4'd3: mr[d] = dv | sv;
          4'd4: mr[d] = dv ^ sv;
          4'd5: mr[d] = ~sv;
          4'd6: mr[d] = {dv[14:0], 1'b0};
          default: mr[d] = {1'b0, dv[15:1]};
        endcase
        mrw++;
      end
      4'd7: begin mstk.push_front(nxt); nxt = sv; end
      4'd8: if (mr[0] < sv) nxt = imm;
      4'd9: nxt = mstk.pop_front();
      4'd10: mstk.push_front(sv);
      4'd11: begin mr[d] = mstk.pop_front(); mrw++; end
      4'd12: if (!imm[7]) begin miow++; mioa = imm; miod = sv; end
             else begin mr[d] = iodat; mrw++; end
      4'd13: begin mhalt = 1; nxt = mpc; end
      4'd14: nxt = imm;
      default: nxt = sv;
    endcase
    mpc = nxt;
  endtask
  // Picks an instruction that keeps code in 0x00-0x7F, data in 0x80-0xFF and the stack in range.
  task automatic gen(output logic [15:0] ins);
    bit ok;
    logic [3:0] op;
    logic [1:0] d, s;
    logic [7:0] i8;
    ok = 0;
    while (!ok) begin
      op = 4'($urandom_range(0, 15)); d = 2'($urandom_range(0, 3)); s = 2'($urandom_range(0, 3));
      i8 = 8'($urandom_range(0, 255)); ok = 1;
      case (op)
        4'd2, 4'd3: i8[7] = 1'b1;
        4'd4: ok = mr[s][7];
        4'd5: ok = mr[d][7];
        4'd7: ok = mstk.size() < 15 && mr[s] < 16'h80;
        4'd8, 4'd14: i8[7] = 1'b0;
        4'd9: ok = mstk.size() > 0 && mstk[0] < 16'h80;
        4'd10: ok = mstk.size() < 15;
        4'd11: ok = mstk.size() > 0;
        4'd13: ok = $urandom_range(0, 19) == 0;
        4'd15: ok = mr[s] < 16'h80;
        default: ;
      endcase
    end
    ins = {op, d, s, i8};
  endtask
  task automatic rand_run(input int k);
    int cost, t, n, b_rw, b_mw, b_io, b_st, mm;
    logic [15:0] ins;
    t = 0; n = 0;
    for (int i = 0; i < 256; i++) im[i] = 16'($urandom);
    for (int i = 0; i < 128; i++) vis[i] = 0;
    for (int i = 0; i < 4; i++) mr[i] = 16'h0;
    mmem = im; mpc = 16'h0; mstk.delete(); mrw = 0; mmw = 0; miow = 0; mhalt = 0;
    mioa = 16'h0; miod = 16'h0; iodat = 16'($urandom);
    while (!mhalt && mpc < 16'h80 && !vis[mpc[6:0]] && n < 40) begin
      gen(ins);
      im[mpc[7:0]] = ins; mmem[mpc[7:0]] = ins; vis[mpc[6:0]] = 1;
      iss(ins, cost);
      t += cost; n++;
    end
    for (int i = 0; i < 256; i++) ram[i] <= im[i];
    boot();
    b_rw = rw_cnt; b_mw = mw_cnt; b_io = io_cnt;
    cyc(t);
    for (int i = 0; i < 4; i++) chk($sformatf("run%0d r%0d", k, i), dut.r[i], mr[i]);
    chk($sformatf("run%0d pc", k), dut.pc, mpc);
    chk($sformatf("run%0d depth", k), 16'(dut.sp), 16'(mstk.size()));
    if (mstk.size() > 0) chk($sformatf("run%0d st0", k), dut.st0, mstk[0]);
    mm = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mmem[i]) mm++;
    chk($sformatf("run%0d mem diffs", k), 16'(mm), 16'h0);
    chk($sformatf("run%0d reg writes", k), 16'(rw_cnt - b_rw), 16'(mrw));
    chk($sformatf("run%0d mem writes", k), 16'(mw_cnt - b_mw), 16'(mmw));
    chk($sformatf("run%0d io writes", k), 16'(io_cnt - b_io), 16'(miow));
    if (miow > 0) begin
      chk($sformatf("run%0d io addr", k), io_a, mioa);
      chk($sformatf("run%0d io data", k), io_d, miod);
    end
    if (mhalt) begin
      b_st = strobe_cnt;
      cyc(5);
      chk($sformatf("run%0d halt pc", k), dut.pc, mpc);
      chk($sformatf("run%0d halt strobes", k), 16'(strobe_cnt - b_st), 16'h0);
    end
  endtask
  initial begin
    int b;
    load('{16'h1005, 16'h1407, 16'h6100, 16'hD000});
    resetq = 1'b1;
    #1 resetq = 1'b0;
    #1;
    chk("reset pc", dut.pc, 16'h0);
    chk("reset mem_read_enable", 16'(bus.mem_read_enable), 16'h0);
    chk("reset mem_read_address", bus.mem_read_address, 16'h0);
    chk("reset reg we", 16'(dut.register_write_enable), 16'h0);
    boot();
    cyc(8);
    chk("add A", dut.r[0], 16'h000C);
    chk("add B", dut.r[1], 16'h0007);
    chk("halt pc", dut.pc, 16'h0003);
    b = strobe_cnt;
    cyc(4);
    chk("halt pc frozen", dut.pc, 16'h0003);
    chk("halt no strobes", 16'(strobe_cnt - b), 16'h0);
    load('{16'h100C, 16'hA000, 16'hB800, 16'hD000});
    boot();
    cyc(4);
    chk("push st0", dut.st0, 16'h000C);
    chk("push depth", 16'(dut.sp), 16'h1);
    cyc(2);
    chk("pop C", dut.r[2], 16'h000C);
    chk("pop depth", 16'(dut.sp), 16'h0);
    load('{16'h1C42, 16'h3C80, 16'h2480, 16'hD000});
    boot();
    b = mw_cnt;
    cyc(6);
    chk("lda wb pending", dut.r[1], 16'h0000);
    cyc(1);
    chk("lda B", dut.r[1], 16'h0042);
    chk("ldm mem", ram[8'h80], 16'h0042);
    chk("ldm one write", 16'(mw_cnt - b), 16'h1);
    chk("lda pc", dut.pc, 16'h0003);
    load('{16'h1010, 16'h7000, 16'hD000});
    ram[8'h10] <= 16'h9000;
    boot();
    cyc(4);
    chk("cal pc", dut.pc, 16'h0010);
    chk("cal depth", 16'(dut.sp), 16'h1);
    cyc(2);
    chk("ret pc", dut.pc, 16'h0002);
    chk("ret depth", 16'(dut.sp), 16'h0);
    load('{16'h1003, 16'h1405, 16'h8120});
    ram[8'h20] <= 16'hC012;
    boot();
    cyc(6);
    chk("jlt taken", dut.pc, 16'h0020);
    b = io_cnt;
    cyc(2);
    chk("sys one write", 16'(io_cnt - b), 16'h1);
    chk("sys io addr", io_a, 16'h0012);
    chk("sys io data", io_d, 16'h0003);
    load('{16'h1005, 16'h1403, 16'h8120});
    boot();
    cyc(6);
    chk("jlt not taken", dut.pc, 16'h0003);
    load('{16'h1C42, 16'h3C80, 16'hD000});
    ram[8'h80] <= 16'hBEEF;
    boot();
    b = mw_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid exec we", 16'(bus.mem_write_enable), 16'h1);
    resetq = 1'b0;
    #1;
    chk("abort we", 16'(bus.mem_write_enable), 16'h0);
    chk("abort re", 16'(bus.mem_read_enable), 16'h0);
    chk("abort waddr", bus.mem_write_address, 16'h0);
    chk("abort pc", dut.pc, 16'h0);
    chk("abort D", dut.r[3], 16'h0);
    chk("abort ir", dut.ir, 16'h0);
    cyc(1);
    chk("abort mem kept", ram[8'h80], 16'hBEEF);
    chk("abort no write", 16'(mw_cnt - b), 16'h0);
    resetq = 1'b1;
    cyc(4);
    chk("restart D", dut.r[3], 16'h0042);
    chk("restart mem", ram[8'h80], 16'h0042);
    for (int k = 0; k < 30; k++) rand_run(k);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
